// File: rtl/ahb_timer_slave.sv
// AHB-Lite slave with one prescaled down-counter, auto-reload and level irq; zero-wait OKAY register access.
// Illegal accesses get a two-cycle ERROR (hreadyout low only in the first cycle); no other backpressure.
module ahb_timer_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic                  o_irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [1:0]                state_q, state_d;
    logic                      dp_vld_q, dp_vld_d;
    logic                      dp_wr_q, dp_wr_d;
    logic [2:0]                dp_off_q, dp_off_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]     load_q, load_d;
    logic [DATA_WIDTH-1:0]     count_q, count_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                      expired_q, expired_d;

    logic                  accept;
    logic                  legal;
    logic                  wr_en;
    logic                  tick;
    logic                  expire;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  unused_haddr;

    assign unused_haddr = ^i_haddr[ADDR_WIDTH-1:5];

    // hready is low during ERR1 anyway; gating here keeps a stray address phase from latching.
    assign accept = i_hsel & i_hready & i_htrans[1] & (state_q != ST_ERR1);
    assign legal  = (i_hsize == 3'b010) && (i_haddr[1:0] == 2'b00) && (i_haddr[4:2] <= OFF_STATUS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !legal) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = (accept && !legal) ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign dp_vld_d = accept & legal;
    assign dp_wr_d  = i_hwrite;
    assign dp_off_d = i_haddr[4:2];

    assign wr_en  = dp_vld_q & dp_wr_q;
    assign tick   = ctrl_q[0] && (pcnt_q == prescale_q);
    assign expire = tick && (count_q == '0);

    // Timer update first, then bus writes override it where both touch the same field.
    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        if (!ctrl_q[0] || tick) pcnt_d = '0;
        else                    pcnt_d = pcnt_q + 1'b1;
        if (tick) begin
            if (count_q != '0)  count_d   = count_q - 1'b1;
            else if (ctrl_q[1]) count_d   = load_q;
            else                ctrl_d[0] = 1'b0;
        end
        if (wr_en && dp_off_q == OFF_CTRL) ctrl_d = i_hwdata[2:0];
        if (wr_en && dp_off_q == OFF_LOAD) begin
            load_d  = i_hwdata;
            count_d = i_hwdata;
            pcnt_d  = '0;
        end
        if (wr_en && dp_off_q == OFF_PRESCALE) prescale_d = i_hwdata[PRESCALE_WIDTH-1:0];
        expired_d = (expired_q & ~(wr_en && dp_off_q == OFF_STATUS && i_hwdata[0])) | expire;
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q    <= ST_IDLE;
            dp_vld_q   <= 1'b0;
            dp_wr_q    <= 1'b0;
            dp_off_q   <= '0;
            ctrl_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_vld_q   <= dp_vld_d;
            dp_wr_q    <= dp_wr_d;
            dp_off_q   <= dp_off_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            expired_q  <= expired_d;
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (dp_off_q)
            OFF_CTRL:     rdata_mux[2:0] = ctrl_q;
            OFF_LOAD:     rdata_mux = load_q;
            OFF_COUNT:    rdata_mux = count_q;
            OFF_PRESCALE: rdata_mux[PRESCALE_WIDTH-1:0] = prescale_q;
            OFF_STATUS:   rdata_mux[0] = expired_q;
            default:      rdata_mux = '0;
        endcase
    end

    assign o_hrdata    = (dp_vld_q && !dp_wr_q) ? rdata_mux : '0;
    assign o_hreadyout = (state_q != ST_ERR1);
    assign o_hresp     = (state_q != ST_IDLE);
    assign o_irq       = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Directed bench for ahb_timer_slave: one task per scenario, inline checks, single summary line.
module tb_ahb_timer_slave;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_LOAD     = 32'h04;
    localparam logic [31:0] A_COUNT    = 32'h08;
    localparam logic [31:0] A_PRESCALE = 32'h0C;
    localparam logic [31:0] A_STATUS   = 32'h10;

    logic        clk;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        irq;

    int n_checks;
    int n_errors;

    assign hready = hreadyout;

    ahb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
        .i_hclk      (clk),
        .i_hreset    (rst),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready),
        .o_hrdata    (hrdata),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the data-phase closing edge.
    task automatic bus_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, output logic rdy, output logic resp,
                            output logic [31:0] rdata);
        hsel   = 1'b1;
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        @(posedge clk); #1;
        bus_idle();
        hwdata = wdata;
        @(negedge clk);
        rdy   = hreadyout;
        resp  = hresp;
        rdata = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        logic        unused_rdy, unused_resp;
        logic [31:0] unused_rd;
        bus_xfer(addr, 1'b1, 3'b010, data, unused_rdy, unused_resp, unused_rd);
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] d);
        logic unused_rdy, unused_resp;
        bus_xfer(addr, 1'b0, 3'b010, 32'h0, unused_rdy, unused_resp, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        bus_idle();
        haddr = 32'h0; hsize = 3'b010; hwdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_errors++; $display("FAIL reset_hreadyout: got %b exp 1", hreadyout); end
        n_checks++; if (hresp !== 1'b0) begin n_errors++; $display("FAIL reset_hresp: got %b exp 0", hresp); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        n_checks++; if (hrdata !== 32'h0) begin n_errors++; $display("FAIL reset_hrdata: got %h exp 0", hrdata); end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            rd32(32'(i * 4), d);
            n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reset_reg_%0d: got %h exp 0", i, d); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        wr32(A_LOAD, 32'd5);
        wr32(A_PRESCALE, 32'd0);
        wr32(A_CTRL, 32'h5);
        hsel = 1'b1; haddr = A_COUNT; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (hrdata !== 32'(4 - i)) begin n_errors++; $display("FAIL oneshot_count_%0d: got %h exp %h", i, hrdata, 32'(4 - i)); end
            n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL oneshot_irq_early_%0d: got %b exp 0", i, irq); end
            @(posedge clk);
        end
        #1;
        bus_idle();
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL oneshot_irq_6th_tick: got %b exp 1", irq); end
        n_checks++; if (hrdata !== 32'h0) begin n_errors++; $display("FAIL oneshot_count_zero: got %h exp 0", hrdata); end
        @(posedge clk); #1;
        rd32(A_CTRL, d);
        n_checks++; if (d !== 32'h4) begin n_errors++; $display("FAIL oneshot_ctrl_en_cleared: got %h exp 4", d); end
        rd32(A_STATUS, d);
        n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL oneshot_status: got %h exp 1", d); end
        rd32(A_COUNT, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL oneshot_count_stays0: got %h exp 0", d); end
        wr32(A_STATUS, 32'h1);
        wr32(A_CTRL, 32'h0);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL oneshot_irq_cleared: got %b exp 0", irq); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        logic [31:0] seq [3];
        seq[0] = 32'd2; seq[1] = 32'd1; seq[2] = 32'd0;
        wr32(A_LOAD, 32'd2);
        wr32(A_PRESCALE, 32'd3);
        wr32(A_CTRL, 32'h3);
        hsel = 1'b1; haddr = A_COUNT; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk);
        for (int k = 1; k < 24; k++) begin
            @(negedge clk);
            n_checks++; if (hrdata !== seq[(k / 4) % 3]) begin n_errors++; $display("FAIL autoreload_count_k%0d: got %h exp %h", k, hrdata, seq[(k / 4) % 3]); end
            @(posedge clk);
        end
        #1;
        bus_idle();
        @(posedge clk); #1;
        wr32(A_CTRL, 32'h0);
        rd32(A_STATUS, d);
        n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL autoreload_status_set: got %h exp 1", d); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL autoreload_irq_masked: got %b exp 0", irq); end
        wr32(A_STATUS, 32'h1);
        rd32(A_STATUS, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL autoreload_w1c: got %h exp 0", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        rdy, resp;
        logic [31:0] e_addr [3];
        logic        e_wr   [3];
        logic [2:0]  e_size [3];
        logic [31:0] e_data [3];
        e_addr[0] = 32'h14; e_wr[0] = 1'b0; e_size[0] = 3'b010; e_data[0] = 32'h0;
        e_addr[1] = 32'h00; e_wr[1] = 1'b1; e_size[1] = 3'b000; e_data[1] = 32'h7;
        e_addr[2] = 32'h06; e_wr[2] = 1'b1; e_size[2] = 3'b010; e_data[2] = 32'hFFFF;
        wr32(A_LOAD, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            bus_xfer(e_addr[i], e_wr[i], e_size[i], e_data[i], rdy, resp, d);
            n_checks++; if (rdy !== 1'b0 || resp !== 1'b1) begin n_errors++; $display("FAIL err%0d_cycle1: got rdy=%b resp=%b exp rdy=0 resp=1", i, rdy, resp); end
            @(negedge clk);
            n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin n_errors++; $display("FAIL err%0d_cycle2: got rdy=%b resp=%b exp rdy=1 resp=1", i, hreadyout, hresp); end
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_errors++; $display("FAIL err%0d_back_idle: got rdy=%b resp=%b exp rdy=1 resp=0", i, hreadyout, hresp); end
            @(posedge clk); #1;
        end
        // a second illegal access accepted in ERR2 goes straight back to ERR1
        bus_xfer(32'h14, 1'b0, 3'b010, 32'h0, rdy, resp, d);
        hsel = 1'b1; haddr = 32'h18; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        n_checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin n_errors++; $display("FAIL err_in_err2: got rdy=%b resp=%b exp rdy=0 resp=1", hreadyout, hresp); end
        repeat (2) @(posedge clk);
        #1;
        rd32(A_LOAD, d);
        n_checks++; if (d !== 32'h1234) begin n_errors++; $display("FAIL err_load_unchanged: got %h exp 1234", d); end
        rd32(A_CTRL, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL err_ctrl_unchanged: got %h exp 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        rdy, resp;
        bus_xfer(A_COUNT, 1'b1, 3'b010, 32'hFF, rdy, resp, d);
        n_checks++; if (rdy !== 1'b1 || resp !== 1'b0) begin n_errors++; $display("FAIL count_wr_okay: got rdy=%b resp=%b exp rdy=1 resp=0", rdy, resp); end
        rd32(A_COUNT, d);
        n_checks++; if (d !== 32'h1234) begin n_errors++; $display("FAIL count_read_only: got %h exp 1234", d); end
        hsel = 1'b1; haddr = A_LOAD; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'hA5A5_0F0F; hwrite = 1'b0;
        @(negedge clk);
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_errors++; $display("FAIL b2b_write_phase: got rdy=%b resp=%b exp rdy=1 resp=0", hreadyout, hresp); end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        n_checks++; if (hrdata !== 32'hA5A5_0F0F || hreadyout !== 1'b1) begin n_errors++; $display("FAIL b2b_read_load: got %h rdy=%b exp a5a50f0f rdy=1", hrdata, hreadyout); end
        @(posedge clk); #1;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        wr32(A_LOAD, 32'd3);
        wr32(A_PRESCALE, 32'd0);
        wr32(A_CTRL, 32'h7);
        repeat (6) @(posedge clk);
        #1;
        hsel = 1'b1; haddr = A_STATUS; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'h1;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL w1c_irq_before: got %b exp 1", irq); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL w1c_vs_expiry_irq: got %b exp 1", irq); end
        @(posedge clk); #1;
        wr32(A_CTRL, 32'h4);
        rd32(A_STATUS, d);
        n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL w1c_vs_expiry_status: got %h exp 1", d); end
        wr32(A_STATUS, 32'h1);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL w1c_plain_irq: got %b exp 0", irq); end
    endtask

    task automatic test_reset_in_err1();
        logic [31:0] d;
        wr32(A_LOAD, 32'd100);
        wr32(A_CTRL, 32'h5);
        hsel = 1'b1; haddr = 32'h14; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        bus_idle();
        n_checks++; if (hreadyout !== 1'b0) begin n_errors++; $display("FAIL rst_err1_entered: got %b exp 0", hreadyout); end
        rst = 1'b1;
        #1;
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_errors++; $display("FAIL rst_err1_resp: got rdy=%b resp=%b exp rdy=1 resp=0", hreadyout, hresp); end
        n_checks++; if (irq !== 1'b0 || hrdata !== 32'h0) begin n_errors++; $display("FAIL rst_err1_irq_rdata: got irq=%b rdata=%h exp 0/0", irq, hrdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd32(A_COUNT, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL rst_err1_count: got %h exp 0", d); end
        rd32(A_CTRL, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL rst_err1_ctrl: got %h exp 0", d); end
    endtask

    task automatic test_idle_busy();
        logic [31:0] d;
        hsel = 1'b1; haddr = A_CTRL; htrans = 2'b01; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'h7; htrans = 2'b00; haddr = A_LOAD;
        @(negedge clk);
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_errors++; $display("FAIL busy_okay: got rdy=%b resp=%b exp rdy=1 resp=0", hreadyout, hresp); end
        @(posedge clk); #1;
        hwdata = 32'h55; hsel = 1'b0; htrans = 2'b10;
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        rd32(A_CTRL, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL busy_ctrl_untouched: got %h exp 0", d); end
        rd32(A_LOAD, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL unsel_load_untouched: got %h exp 0", d); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = 32'h0;
        rst = 1'b1;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_errors();
        test_back_to_back();
        test_w1c_collision();
        test_reset_in_err1();
        test_idle_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_timer_slave.md
Name: ahb_timer_slave

Overview:
- AHB-Lite slave holding one down-counting timer with prescaler, auto-reload and interrupt.
- Sits directly downstream of the interconnect decoder/mux as slave 3, at base 0xAC00.
- Consumes its decoded select line and drives that slave's hrdata/hresp/hreadyout inputs back into the mux.
- Registers are accessed with zero-wait OKAY transfers; illegal accesses get a two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; also the LOAD/COUNT width.
- PRESCALE_WIDTH, 16, width of the PRESCALE register and the internal prescale counter.

Ports:
- i_hclk  in  1  bus clock; all timing on rising edge.
- i_hreset  in  1  asynchronous, active-high reset.
- i_hsel  in  1  slave select from the decoder.
- i_haddr  in  ADDR_WIDTH  transfer address; bits [4:0] used.
- i_htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- i_hwrite  in  1  1=write, 0=read.
- i_hsize  in  3  transfer size; only 3'b010 (word) is legal.
- i_hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- i_hready  in  1  bus-level hready (muxed) from the interconnect.
- o_hrdata  out  DATA_WIDTH  read data.
- o_hreadyout  out  1  slave ready.
- o_hresp  out  1  0=OKAY, 1=ERROR.
- o_irq  out  1  level interrupt.

Behaviour:
- Reset values (asynchronous, i_hreset=1):
  - CTRL, LOAD, COUNT, PRESCALE, STATUS and the prescale counter = 0.
  - FSM = IDLE.
  - o_hrdata=0, o_hreadyout=1, o_hresp=0, o_irq=0.
  - Reset asserted mid-transfer or mid-ERROR returns to IDLE immediately.
- Address phase is accepted when i_hsel & i_hready & i_htrans[1]. On acceptance, latch offset=i_haddr[4:2], write flag, and a valid flag.
- BUSY/IDLE transfers and unselected cycles: no latch, OKAY response, no register effect.
- Legal access requires all of:
  - i_hsize==3'b010
  - i_haddr[1:0]==0
  - offset<=4
- Register map:
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 LOAD.
  - 0x08 COUNT: read-only; writes ignored with OKAY.
  - 0x0C PRESCALE.
  - 0x10 STATUS: [0] EXPIRED, write-1-to-clear.
- Legal write: in the data-phase cycle following acceptance, the register updates from i_hwdata at that cycle's clock edge. o_hreadyout=1, o_hresp=0 (zero wait).
- Writing LOAD also sets COUNT=LOAD and clears the prescale counter.
- Legal read: o_hrdata = selected register value during the data-phase cycle, zero wait. o_hrdata=0 outside read data phases.
- Response FSM: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 on acceptance of an illegal access.
  - ERR1: o_hreadyout=0, o_hresp=1; -> ERR2.
  - ERR2: o_hreadyout=1, o_hresp=1; -> IDLE, or straight to ERR1 if another illegal access is accepted in ERR2.
  - Illegal accesses never modify registers.
  - Address phases presented during ERR1 are not accepted (i_hready=0).
- Timer, when EN=1:
  - The prescale counter increments each cycle. tick = (pcnt==PRESCALE), and pcnt wraps to 0 on tick. PRESCALE=0 gives a tick every cycle.
  - On tick with COUNT!=0: COUNT decrements.
  - On tick with COUNT==0: EXPIRED<=1. If AUTO_RELOAD, COUNT<=LOAD; else EN<=0 (one-shot stop, COUNT stays 0).
- Timer, when EN=0: pcnt held at 0 and COUNT frozen.
- Simultaneous events:
  - Expiry set beats a STATUS W1C in the same cycle (EXPIRED ends 1).
  - A CTRL bus write beats the one-shot EN clear.
  - A LOAD write beats a tick decrement.
- o_irq = EXPIRED & IRQ_EN, derived from registered state only.

Test Plan:
- Write LOAD=5, PRESCALE=0, CTRL=0x5 (EN+IRQ_EN) -> COUNT reads 4,3,..; EXPIRED=1 and o_irq=1 on the 6th tick after EN; CTRL reads 0x4 (EN cleared); COUNT=0.
- LOAD=2, PRESCALE=3, CTRL=0x3 -> COUNT changes every 4 cycles, sequence 2,1,0,2,1,0; STATUS[0]=1 after the first wrap; writing STATUS=1 clears it.
- Read at 0x14, write with i_hsize=3'b000, and access at 0x06 -> each gives cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1; registers unchanged.
- Write COUNT=0xFF -> OKAY zero-wait, COUNT unchanged. Back-to-back NONSEQ write LOAD then read LOAD -> read returns the written value with no wait states.
- Issue a STATUS W1C in the same cycle as an expiry tick -> STATUS[0] remains 1 and o_irq stays 1.
- Assert i_hreset during ERR1 with timer running -> all outputs at reset values next sample, COUNT=0, o_hreadyout=1.
